// File: rtl/sha3_sponge_ctrl.sv
// SHA-3 sponge host controller for a two-share masked Keccak-f[1600] core.
// Absorbs a masked word stream with padding on share 0, permutes, then squeezes share pairs.
module sha3_sponge_ctrl #(
    parameter int unsigned RATE_WORDS = 34,
    parameter int unsigned OUT_WORDS  = 8,
    parameter logic [7:0]  DSBYTE     = 8'h06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data_0,
    input  logic [31:0] in_data_1,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data_0,
    output logic [31:0] out_data_1,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        core_init,
    output logic        core_go,
    output logic        core_absorb,
    output logic        core_extend,
    output logic        core_squeeze,
    output logic        core_squeeze_indx,
    output logic [31:0] core_din_0,
    output logic [31:0] core_din_1,
    input  logic        core_done,
    input  logic [31:0] core_result
);

    localparam logic [5:0] RateLast = 6'(RATE_WORDS - 1);
    localparam logic [5:0] OutLast  = 6'(OUT_WORDS - 1);
    localparam logic [5:0] ExtLast  = 6'd49;

    typedef enum logic [3:0] {
        StIdle, StInit, StAbsorb, StPad, StExtend, StPerm, StSqz0, StSqz1, StSqzWait, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  wcnt_q, wcnt_d;
    logic        msg_end_q, msg_end_d;
    logic        pad_pending_q, pad_pending_d;
    logic        go_sent_q, go_sent_d;

    logic        init_d, go_d, absorb_d, extend_d, squeeze_d, sqz_indx_d;
    logic [31:0] din_0_d, din_1_d;

    logic        short_last;
    logic [4:0]  byte_sh;
    logic [31:0] keep_mask, ds_word, end_word, pad_word;

    // Short last word: bytes at and above in_bytes are dropped from both shares,
    // the domain byte lands at in_bytes in share 0 only.
    always_comb begin
        short_last = in_last && (in_bytes < 3'd4);
        byte_sh    = {in_bytes[1:0], 3'b000};
        keep_mask  = short_last ? ~(32'hffff_ffff << byte_sh) : 32'hffff_ffff;
        ds_word    = short_last ? ({24'h0, DSBYTE} << byte_sh) : 32'h0;
        end_word   = (short_last && (wcnt_q == RateLast)) ? 32'h8000_0000 : 32'h0;
        pad_word   = (pad_pending_q ? {24'h0, DSBYTE} : 32'h0) |
                     ((wcnt_q == RateLast) ? 32'h8000_0000 : 32'h0);
    end

    assign in_ready = (state_q == StAbsorb);
    assign busy     = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        msg_end_d     = msg_end_q;
        pad_pending_d = pad_pending_q;
        go_sent_d     = go_sent_q;
        init_d        = 1'b0;
        go_d          = 1'b0;
        absorb_d      = 1'b0;
        extend_d      = 1'b0;
        squeeze_d     = 1'b0;
        sqz_indx_d    = 1'b0;
        din_0_d       = 32'h0;
        din_1_d       = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StInit;
            end
            StInit: begin
                init_d        = 1'b1;
                wcnt_d        = '0;
                msg_end_d     = 1'b0;
                pad_pending_d = 1'b0;
                state_d       = StAbsorb;
            end
            StAbsorb: begin
                if (in_valid) begin
                    absorb_d = 1'b1;
                    din_1_d  = in_data_1 & keep_mask;
                    din_0_d  = (in_data_0 & keep_mask) ^ ds_word ^ end_word;
                    wcnt_d   = wcnt_q + 6'd1;
                    if (in_last) begin
                        msg_end_d     = 1'b1;
                        pad_pending_d = !short_last;
                    end
                    if (wcnt_q == RateLast) state_d = StExtend;
                    else if (in_last)       state_d = StPad;
                end
            end
            StPad: begin
                absorb_d      = 1'b1;
                din_0_d       = pad_word;
                pad_pending_d = 1'b0;
                wcnt_d        = wcnt_q + 6'd1;
                if (wcnt_q == RateLast) state_d = StExtend;
            end
            StExtend: begin
                // Rotate the unused capacity words past so absorbed word k sits at word k.
                extend_d  = 1'b1;
                go_sent_d = 1'b0;
                wcnt_d    = wcnt_q + 6'd1;
                if (wcnt_q == ExtLast) state_d = StPerm;
            end
            StPerm: begin
                if (!go_sent_q) begin
                    go_d      = 1'b1;
                    go_sent_d = 1'b1;
                end else if (core_done) begin
                    wcnt_d = '0;
                    if (msg_end_q && !pad_pending_q) state_d = StSqz0;
                    else if (pad_pending_q)          state_d = StPad;
                    else                             state_d = StAbsorb;
                end
            end
            StSqz0: begin
                squeeze_d = 1'b1;
                state_d   = StSqz1;
            end
            StSqz1: begin
                squeeze_d  = 1'b1;
                sqz_indx_d = 1'b1;
                state_d    = StSqzWait;
            end
            StSqzWait: begin
                if (out_valid && out_ready) begin
                    wcnt_d  = wcnt_q + 6'd1;
                    state_d = (wcnt_q == OutLast) ? StDone : StSqz0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            wcnt_q            <= '0;
            msg_end_q         <= 1'b0;
            pad_pending_q     <= 1'b0;
            go_sent_q         <= 1'b0;
            core_init         <= 1'b0;
            core_go           <= 1'b0;
            core_absorb       <= 1'b0;
            core_extend       <= 1'b0;
            core_squeeze      <= 1'b0;
            core_squeeze_indx <= 1'b0;
            core_din_0        <= 32'h0;
            core_din_1        <= 32'h0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            out_data_0        <= 32'h0;
            out_data_1        <= 32'h0;
        end else begin
            state_q           <= state_d;
            wcnt_q            <= wcnt_d;
            msg_end_q         <= msg_end_d;
            pad_pending_q     <= pad_pending_d;
            go_sent_q         <= go_sent_d;
            core_init         <= init_d;
            core_go           <= go_d;
            core_absorb       <= absorb_d;
            core_extend       <= extend_d;
            core_squeeze      <= squeeze_d;
            core_squeeze_indx <= sqz_indx_d;
            core_din_0        <= din_0_d;
            core_din_1        <= din_1_d;
            // core_result is sampled while the squeeze command is live at the core.
            if (core_squeeze && !core_squeeze_indx) out_data_0 <= core_result;
            if (core_squeeze && core_squeeze_indx) begin
                out_data_1 <= core_result;
                out_valid  <= 1'b1;
                out_last   <= (wcnt_q == OutLast);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sha3_sponge_ctrl.md
Name: sha3_sponge_ctrl

Overview:
- Sponge-level host controller that drives the two-share masked Keccak-f[1600] core through its 32-bit word command interface.
- Accepts a masked message stream (two 32-bit shares per word) and applies SHA-3 padding to share 0 only.
- Absorbs each rate block (word shift, then extend-realign), launches each permutation and waits for its completion pulse.
- Squeezes the digest back out as share pairs. Sits between the bus/DMA front-end and the masked permutation core.

Parameters:
- RATE_WORDS, 34, rate in 32-bit words (34 = SHA3-256); legal range 1..49.
- OUT_WORDS, 8, digest length in words; 1 <= OUT_WORDS <= RATE_WORDS (single-block squeeze only).
- DSBYTE, 8'h06, domain-separation/pad start byte.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin new message (pulse); ignored while busy=1
- in_valid  in  1  message word valid
- in_ready  out  1  controller accepts word
- in_data_0  in  32  message share 0
- in_data_1  in  32  message share 1
- in_last  in  1  final message word
- in_bytes  in  3  valid bytes in final word, 0..4; byte i = bits [8i+7:8i]; ignored (treated as 4) when in_last=0
- out_valid  out  1  digest word pair valid
- out_ready  in  1  sink accepts digest word
- out_data_0  out  32  digest share 0
- out_data_1  out  32  digest share 1
- out_last  out  1  final digest word
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after last digest word accepted
- core_init  out  1  clear core state
- core_go  out  1  start permutation (pulse)
- core_absorb  out  1  shift-XOR core_din into both shares
- core_extend  out  1  rotate both shares by one word
- core_squeeze  out  1  rotate selected share by one word
- core_squeeze_indx  out  1  share select for squeeze
- core_din_0  out  32  absorb word share 0
- core_din_1  out  32  absorb word share 1
- core_done  in  1  permutation complete pulse
- core_result  in  32  word 0 of selected share (combinational, pre-shift)

Behaviour:
- Reset (rst_n=0 at an edge): FSM -> IDLE. All outputs 0; out_data_* = 0. Applies at any point including mid-message; the core shares the same rst_n.
- All core_* outputs are registered: a command chosen in FSM cycle t reaches the core at t+1. Commands are mutually exclusive, at most one per cycle. Command order is preserved.
- IDLE: start -> INIT, busy=1.
- INIT (1 cycle): issue core_init -> ABSORB; wcnt=0; pad_pending=0.
- ABSORB:
  - in_ready=1 while wcnt<RATE_WORDS and message not yet ended.
  - On handshake: issue core_absorb with din_1=in_data_1 and din_0=in_data_0 XOR pad; wcnt++.
  - Pad for a last word with in_bytes=b<4: DSBYTE at byte b; bytes above b forced to 0 in both shares.
  - If wcnt==RATE_WORDS-1, also OR 8'h80 into byte 3 (b=3 gives 8'h86 there).
  - Last word with b=4: pad_pending=1.
- PAD (after the message ends, block not full): in_ready=0. Issue one absorb word per cycle with share1=0.
  - First pad word carries DSBYTE at byte 0, only if pad_pending.
  - The word at wcnt==RATE_WORDS-1 carries 8'h80 at byte 3.
  - Other pad words are 0.
  - If a b=4 last word fills the block exactly, the block permutes unpadded and padding occupies the next block.
- EXTEND: when wcnt==RATE_WORDS, issue core_extend for exactly 50-RATE_WORDS consecutive cycles (realigns lanes) -> PERM.
- PERM: issue core_go for one cycle; hold all commands low until core_done.
  - If the message is complete -> SQZ0, wcnt=0.
  - Otherwise -> ABSORB (or PAD if pad_pending), wcnt=0.
- SQZ0: issue core_squeeze, indx=0. Capture core_result into out_data_0 in the cycle that command is live.
- SQZ1: same with indx=1, capturing into out_data_1. Set out_valid the cycle after capture; out_last=(wcnt==OUT_WORDS-1).
- SQZ_WAIT: hold out_valid and data stable, no core commands, until out_ready.
  - On handshake: out_valid=0 and wcnt++.
  - If wcnt==OUT_WORDS -> DONE, else -> SQZ0.
- DONE: done=1 for 1 cycle, busy=0 -> IDLE. The core state is not realigned; the next message re-inits it.
- core_done outside PERM is ignored. start is ignored when not IDLE.

Test Plan:
- Empty message: start; word {in_last=1, in_bytes=0, data 0/0} -> out word0 share0^share1 = 32'hf8c6ffa7 (SHA3-256("") = a7ffc6f8…); exactly 8 out words, out_last on the 8th, one done pulse.
- "abc" masked: in_data_1=32'h5a5a1234, in_data_0=32'h00636261^32'h5a5a1234, in_bytes=3, last -> share XOR of word0 = 32'ha75d983a; core_din_0^core_din_1 for word0 = 32'h06636261, word33 = 32'h80000000.
- 135-byte message (33 full words + last in_bytes=3) -> word33 core_din XOR = {8'h86, data[23:0]}; one permutation only; digest matches the software model.
- 136-byte message (34 words, last in_bytes=4) -> two core_go pulses. After each block, exactly 16 consecutive core_extend cycles precede the core_go pulse. The second block's absorb words are 32'h00000006, zeros, 32'h80000000.
- Backpressure: in_valid toggled 1/0 and out_ready low for 10 cycles per word -> no absorb gaps corrupt the digest; out_valid/data stable while stalled; no core_squeeze issued while out_valid=1.
- Reset mid-PERM and mid-SQZ_WAIT -> next cycle all outputs 0, busy=0. A subsequent "abc" run yields the correct digest.
